clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter CNT_W, default 8, counter and ratio width; legal range 2..16.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 en_i  input  1  run request; high starts or continues output generation.
REQ-005 cfg_valid_i  input  1  new configuration offered on div_i/hi_i.
REQ-006 cfg_ready_o  output  1  configuration shadow free; transfer when cfg_valid_i && cfg_ready_o.
REQ-007 div_i  input  CNT_W  requested period D, in clk_i cycles.
REQ-008 hi_i  input  CNT_W  requested high time H, in clk_i cycles.
REQ-009 clk_o  output  1  divided clock, registered, glitch-free.
REQ-010 tick_o  output  1  one-cycle pulse coincident with each clk_o rising edge (period start).

Function
REQ-011 The block SHALL have states IDLE, RUN and DRAIN.
REQ-012 The block SHALL clamp at capture: D<2 -> 2; H==0 -> 1; H>=D -> D-1.
REQ-013 IDLE: clk_o=0, tick_o=0, cnt=0; en_i=1 sampled at edge k -> RUN at k, cnt=0, clk_o=1, tick_o=1 from k (one-cycle latency).
REQ-014 RUN: each cycle cnt <= (cnt==D-1) ? 0 : cnt+1; clk_o <= (next cnt < H); tick_o <= (next cnt == 0).
REQ-015 RUN with en_i=0 SHALL go to DRAIN; the current period completes unchanged.
REQ-016 DRAIN: counting continues as in RUN; at wrap (cnt==D-1) -> IDLE with clk_o=0, tick_o=0.
REQ-017 en_i=1 in DRAIN SHALL return to RUN with no change to cnt or clk_o (no glitch, no restart).
REQ-018 A handshake SHALL capture clamped D/H into a shadow, set pending, and drive cfg_ready_o=0 from the next cycle.
REQ-019 In IDLE the shadow SHALL become active on the cycle after capture; cfg_ready_o returns to 1 that same cycle.
REQ-020 In RUN/DRAIN a pending shadow SHALL become active only at a wrap edge, so the new period starts with new D/H; cfg_ready_o returns to 1 on that edge.
REQ-021 A handshake coinciding with a wrap edge SHALL NOT apply at that wrap; it applies at the following wrap.
REQ-022 cfg_valid_i while cfg_ready_o=0 SHALL be ignored (no overwrite of pending shadow).
REQ-023 Periods SHALL never be truncated or stretched except by a rst_i assertion.
REQ-024 The counter SHALL use CNT_W bits; D up to 2^CNT_W-1 SHALL be exact with no overflow.

Reset
REQ-025 rst_i=1 at an edge SHALL force IDLE, cnt=0, clk_o=0, tick_o=0, active D=2, H=1, pending=0, cfg_ready_o=1.
REQ-026 Reset mid-period SHALL abort immediately; any pending configuration is discarded.
REQ-027 rst_i SHALL take priority over en_i and cfg_valid_i in the same cycle.

Configuration
REQ-028 Macro CLK_DIV_GEN_PCNT_EN defined: the block SHALL add output per_cnt_o [15:0], completed-period counter.
REQ-029 per_cnt_o SHALL be reset to 0 and increment by 1 on each tick_o after the first since leaving IDLE; it wraps 0xFFFF -> 0x0000.
REQ-030 Macro undefined: per_cnt_o and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, en_i=1, no config -> clk_o 1,0,1,0...; tick_o every 2 cycles, first one cycle after en_i.
REQ-032 In IDLE, config D=5, H=2; en_i=1 -> clk_o 1,1,0,0,0 repeating; tick_o every 5 cycles.
REQ-033 RUN at D=5,H=2; config D=3,H=1 offered at cnt=1 -> current period completes with 5 cycles, then 1,0,0; cfg_ready_o low until the wrap.
REQ-034 Clamping: offer D=1,H=0, then D=4,H=7 -> 2-cycle period with H=1, then 4-cycle period with H=3.
REQ-035 en_i dropped at cnt=1 of D=6 -> 4 more cycles, then IDLE with clk_o=0; repeat and reassert en_i in DRAIN -> uninterrupted waveform.
REQ-036 rst_i asserted at cnt=3 with pending config -> next cycle clk_o=0, cfg_ready_o=1, D=2 on restart; with CLK_DIV_GEN_PCNT_EN, per_cnt_o=0.

Source files
------------

// File: rtl/clk_div_gen.sv
// Programmable clock divider with handshake-loaded period/high-time, applied only at period boundaries.
// Optional completed-period counter output per_cnt_o when CLK_DIV_GEN_PCNT_EN is defined.
`timescale 1ns/1ps

module clk_div_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] hi_i,
    output logic             clk_o,
    output logic             tick_o
`ifdef CLK_DIV_GEN_PCNT_EN
    ,
    output logic [15:0]      per_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] act_hi_q, act_hi_d;
    logic [CNT_W-1:0] shd_div_q, shd_div_d;
    logic [CNT_W-1:0] shd_hi_q, shd_hi_d;
    logic             pend_q, pend_d;
`ifdef CLK_DIV_GEN_PCNT_EN
    logic [15:0]      per_cnt_q, per_cnt_d;
`endif

    logic [CNT_W-1:0] div_clamp;
    logic [CNT_W-1:0] hi_clamp;
    logic             at_wrap;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        div_clamp = (div_i < CNT_TWO) ? CNT_TWO : div_i;
        if (hi_i == '0) begin
            hi_clamp = CNT_ONE;
        end else if (hi_i >= div_clamp) begin
            hi_clamp = div_clamp - CNT_ONE;
        end else begin
            hi_clamp = hi_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        act_div_d = act_div_q;
        act_hi_d  = act_hi_q;
        shd_div_d = shd_div_q;
        shd_hi_d  = shd_hi_q;
        pend_d    = pend_q;
`ifdef CLK_DIV_GEN_PCNT_EN
        per_cnt_d = per_cnt_q;
`endif
        at_wrap = (cnt_q == act_div_q - CNT_ONE);
        cnt_inc = at_wrap ? '0 : cnt_q + CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    act_div_d = shd_div_q;
                    act_hi_d  = shd_hi_q;
                    pend_d    = 1'b0;
                end
                if (en_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end
            end
            RUN, DRAIN: begin
                state_d = en_i ? RUN : DRAIN;
                cnt_d   = cnt_inc;
                // At wrap cnt_inc is 0, which is below any legal H, so the new period always starts high.
                clk_d   = (cnt_inc < act_hi_q);
                tick_d  = at_wrap;
                if (at_wrap) begin
                    if (pend_q) begin
                        act_div_d = shd_div_q;
                        act_hi_d  = shd_hi_q;
                        pend_d    = 1'b0;
                    end
                    if ((state_q == DRAIN) && !en_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        clk_d   = 1'b0;
                        tick_d  = 1'b0;
                    end
`ifdef CLK_DIV_GEN_PCNT_EN
                    else begin
                        per_cnt_d = per_cnt_q + 16'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        // pend_q gates the handshake, so a capture never collides with the shadow being applied.
        if (cfg_valid_i && !pend_q) begin
            shd_div_d = div_clamp;
            shd_hi_d  = hi_clamp;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            act_div_q <= CNT_TWO;
            act_hi_q  <= CNT_ONE;
            shd_div_q <= CNT_TWO;
            shd_hi_q  <= CNT_ONE;
            pend_q    <= 1'b0;
`ifdef CLK_DIV_GEN_PCNT_EN
            per_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            act_div_q <= act_div_d;
            act_hi_q  <= act_hi_d;
            shd_div_q <= shd_div_d;
            shd_hi_q  <= shd_hi_d;
            pend_q    <= pend_d;
`ifdef CLK_DIV_GEN_PCNT_EN
            per_cnt_q <= per_cnt_d;
`endif
        end
    end

    assign clk_o       = clk_q;
    assign tick_o      = tick_q;
    assign cfg_ready_o = ~pend_q;
`ifdef CLK_DIV_GEN_PCNT_EN
    assign per_cnt_o   = per_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a period-list reference model pushes expected outputs per edge,
// a negedge monitor pops and compares. Also checks per_cnt_o when CLK_DIV_GEN_PCNT_EN is defined.
`timescale 1ns/1ps

module tb_clk_div_gen;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             en_i = 1'b0;
    logic             cfg_valid_i = 1'b0;
    logic [CNT_W-1:0] div_i = '0;
    logic [CNT_W-1:0] hi_i = '0;
    logic             cfg_ready_o;
    logic             clk_o;
    logic             tick_o;
`ifdef CLK_DIV_GEN_PCNT_EN
    logic [15:0]      per_cnt_o;
`endif

    always #5 clk = ~clk;

    clk_div_gen #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .div_i       (div_i),
        .hi_i        (hi_i),
        .clk_o       (clk_o),
`ifdef CLK_DIV_GEN_PCNT_EN
        .per_cnt_o   (per_cnt_o),
`endif
        .tick_o      (tick_o)
    );

    typedef struct packed {
        logic        clk;
        logic        tick;
        logic        rdy;
        logic [15:0] pcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference model: the running period is a list of {tick,clk} samples; the head is what is shown now.
    typedef enum {M_IDLE, M_RUN, M_DRAIN} mmode_t;
    mmode_t      m_mode = M_IDLE;
    logic [1:0]  m_wave[$];
    int          m_act_d = 2, m_act_h = 1, m_shd_d = 2, m_shd_h = 1, m_cur_d = 2;
    bit          m_pend = 1'b0;
    logic [15:0] m_pcnt = '0;

    task automatic start_period();
        m_wave.delete();
        for (int i = 0; i < m_act_d; i++) m_wave.push_back({(i == 0), (i < m_act_h)});
        m_cur_d = m_act_d;
    endtask

    task automatic apply_shadow();
        m_act_d = m_shd_d;
        m_act_h = m_shd_h;
        m_pend  = 1'b0;
    endtask

    function automatic int model_cnt();
        return (m_mode == M_IDLE) ? -1 : m_cur_d - m_wave.size();
    endfunction

    task automatic model_step();
        bit   take;
        int   d, h;
        exp_t e;
        if (rst_i) begin
            m_mode = M_IDLE;
            m_wave.delete();
            m_act_d = 2; m_act_h = 1; m_pend = 1'b0; m_pcnt = '0;
        end else begin
            take = cfg_valid_i && !m_pend;
            if (m_mode == M_IDLE) begin
                if (m_pend) apply_shadow();
                if (en_i) begin
                    m_mode = M_RUN;
                    start_period();
                end
            end else if (m_wave.size() > 1) begin
                void'(m_wave.pop_front());
                m_mode = en_i ? M_RUN : M_DRAIN;
            end else begin
                if (m_pend) apply_shadow();
                if (m_mode == M_DRAIN && !en_i) begin
                    m_mode = M_IDLE;
                    m_wave.delete();
                end else begin
                    m_mode = en_i ? M_RUN : M_DRAIN;
                    start_period();
                    m_pcnt = m_pcnt + 16'd1;
                end
            end
            if (take) begin
                d = (int'(div_i) < 2) ? 2 : int'(div_i);
                h = (hi_i == '0) ? 1 : ((int'(hi_i) >= d) ? d - 1 : int'(hi_i));
                m_shd_d = d; m_shd_h = h; m_pend = 1'b1;
            end
        end
        e.clk  = (m_wave.size() > 0) ? m_wave[0][0] : 1'b0;
        e.tick = (m_wave.size() > 0) ? m_wave[0][1] : 1'b0;
        e.rdy  = !m_pend;
        e.pcnt = m_pcnt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
    endtask

    task automatic set(input logic r, input logic e, input logic v, input int d, input int h);
        rst_i = r; en_i = e; cfg_valid_i = v;
        div_i = d[CNT_W-1:0];
        hi_i  = h[CNT_W-1:0];
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL timeout_%s: condition not reached by cycle %0d, required within bound", name, cyc);
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 1000 && model_cnt() != c; i++) step();
        if (model_cnt() != c) bound_fail("wait_cnt");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && m_mode != M_IDLE; i++) step();
        if (m_mode != M_IDLE) bound_fail("wait_idle");
    endtask

    task automatic wait_free();
        for (int i = 0; i < 1000 && m_pend; i++) step();
        if (m_pend) bound_fail("wait_free");
    endtask

    task automatic offer_now(input int d, input int h);
        cfg_valid_i = 1'b1;
        div_i = d[CNT_W-1:0];
        hi_i  = h[CNT_W-1:0];
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic offer(input int d, input int h);
        wait_free();
        offer_now(d, h);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (clk_o !== e.clk || tick_o !== e.tick || cfg_ready_o !== e.rdy) begin
                    n_err++;
                    $display("FAIL outputs cyc %0d: clk/tick/rdy got %b%b%b required %b%b%b",
                             cyc, clk_o, tick_o, cfg_ready_o, e.clk, e.tick, e.rdy);
                end
`ifdef CLK_DIV_GEN_PCNT_EN
                if (per_cnt_o !== e.pcnt) begin
                    n_err++;
                    $display("FAIL per_cnt cyc %0d: got %0d required %0d", cyc, per_cnt_o, e.pcnt);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        int d, h;
        set(1, 0, 0, 0, 0);
        step(); step();

        // Default D=2,H=1 after reset
        set(0, 1, 0, 0, 0);
        repeat (8) step();
        en_i = 1'b0;
        wait_idle();

        // Configure in IDLE, then run D=5,H=2
        offer(5, 2);
        step(); step();
        en_i = 1'b1;
        repeat (15) step();

        // Mid-period reconfiguration at cnt=1
        wait_cnt(1);
        offer_now(3, 1);
        repeat (14) step();

        // Clamping of illegal values
        offer(1, 0);
        wait_free();
        offer(4, 7);
        repeat (14) step();

        // Handshake on the wrap edge applies one period later
        wait_free();
        wait_cnt(m_cur_d - 1);
        offer_now(6, 3);
        repeat (14) step();

        // Drop enable mid-period, then re-assert during DRAIN
        wait_cnt(1);
        en_i = 1'b0;
        wait_idle();
        repeat (3) step();
        en_i = 1'b1;
        step();
        wait_cnt(1);
        en_i = 1'b0;
        step(); step();
        en_i = 1'b1;
        repeat (12) step();

        // Reset mid-period with a pending config, reset beating en/cfg_valid
        wait_free();
        wait_cnt(0);
        offer_now(9, 4);
        wait_cnt(3);
        set(1, 1, 1, 7, 3);
        step();
        set(0, 1, 0, 0, 0);
        repeat (8) step();

        // Largest representable period
        offer(255, 200);
        repeat (560) step();

        // Randomized traffic
        set(0, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) en_i = ~en_i;
            cfg_valid_i = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) begin
                d = $urandom_range(0, 255);
                h = $urandom_range(0, 255);
            end else begin
                d = $urandom_range(0, 12);
                h = $urandom_range(0, 14);
            end
            div_i = d[CNT_W-1:0];
            hi_i  = h[CNT_W-1:0];
            step();
        end

        set(0, 0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
